// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants for the 4-digit FND scan controller.
//   - APB register byte offsets and their PADDR[3:2] selectors
//   - FCR bit positions
//   - 16-entry active-low segment LUT (bits [6:0], dot excluded)
//   - digit-enable decode helper
package fnd_pkg;

  localparam logic [3:0] OFF_FCR = 4'h0;
  localparam logic [3:0] OFF_FDR = 4'h4;
  localparam logic [3:0] OFF_FPR = 4'h8;
  localparam logic [3:0] OFF_FSR = 4'hC;

  typedef enum logic [1:0] {
    SEL_FCR = 2'd0,
    SEL_FDR = 2'd1,
    SEL_FPR = 2'd2,
    SEL_FSR = 2'd3
  } reg_sel_e;

  localparam int FCR_EN_BIT   = 0;
  localparam int FCR_SYNC_BIT = 1;

  // Entry n is the active-low segment pattern for hex digit n (index 15 listed first).
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low one-hot digit enable for a scan index.
  function automatic logic [3:0] comm_decode(input logic [1:0] idx);
    logic [3:0] comm;
    case (idx)
      2'd0:    comm = 4'b1110;
      2'd1:    comm = 4'b1101;
      2'd2:    comm = 4'b1011;
      2'd3:    comm = 4'b0111;
      default: comm = 4'b1111;
    endcase
    return comm;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_seg.sv
// fnd_seg_decode: maps one digit (nibble, dot, blank) to the active-low
// segment byte driven on fndFont.
//   nibble_i : hex value of the digit
//   dot_i    : 1 lights the decimal point (font bit7 driven low)
//   blank_i  : 1 turns every segment off (font = 8'hFF)
//   font_o   : active-low segments, bit7 = dot
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dot_i,
  input  logic       blank_i,
  output logic [7:0] font_o
);

  // Segment lookup with blank override.
  always_comb begin
    font_o = 8'hFF;
    if (blank_i) begin
      font_o = 8'hFF;
    end else begin
      font_o = {~dot_i, SEG_LUT[nibble_i]};
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: APB-programmed 4-digit multiplexed FND scanner.
//   PCLK/PRESET        : clock, asynchronous active-high reset
//   PADDR..PSEL        : APB slave (one wait state), PRDATA/PREADY registered
//   fndComm            : active-low digit enables
//   fndFont            : active-low segments, bit7 = dot
//   frame_done         : one-cycle pulse on the last tick of digit 3
// Registers: FCR(EN,SYNC) FDR(digits) FPR(dot/blank) FSR(index,pending, RO).
// FDR/FPR writes land in staging copies; the displayed copies follow staging
// every cycle, or only at frame boundaries when EN and SYNC are both set.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  fndComm,
  output logic [7:0]  fndFont,
  output logic        frame_done
);

  localparam int            CW   = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  logic          pready_q,     pready_d;
  logic [31:0]   prdata_q,     prdata_d;
  logic [1:0]    fcr_q,        fcr_d;
  logic [15:0]   stg_fdr_q,    stg_fdr_d;
  logic [7:0]    stg_fpr_q,    stg_fpr_d;
  logic [15:0]   act_fdr_q,    act_fdr_d;
  logic [7:0]    act_fpr_q,    act_fpr_d;
  logic          pending_q,    pending_d;
  logic [CW-1:0] cnt_q,        cnt_d;
  logic [1:0]    idx_q,        idx_d;
  logic          frame_done_q, frame_done_d;

  logic          access_s, wr_s, rd_s, wr_disp_s;
  logic          en_s, sync_mode_s, boundary_s;
  reg_sel_e      sel_s;
  logic [31:0]   rdata_s;
  logic [7:0]    seg_font_s;
  logic          unused_apb_s;

  assign unused_apb_s = ^{PADDR[1:0], PWDATA[31:16]};

  // Next-state logic: APB handshake, register file, copy policy, scan counters.
  always_comb begin
    access_s    = PSEL & PENABLE & ~pready_q;
    wr_s        = access_s & PWRITE;
    rd_s        = access_s & ~PWRITE;
    sel_s       = reg_sel_e'(PADDR[3:2]);
    en_s        = fcr_q[FCR_EN_BIT];
    sync_mode_s = en_s & fcr_q[FCR_SYNC_BIT];
    wr_disp_s   = wr_s & ((sel_s == SEL_FDR) | (sel_s == SEL_FPR));
    // frame_done_q is high exactly on the digit-3 terminal tick.
    boundary_s  = frame_done_q;

    pready_d  = access_s;
    fcr_d     = fcr_q;
    stg_fdr_d = stg_fdr_q;
    stg_fpr_d = stg_fpr_q;
    act_fdr_d = act_fdr_q;
    act_fpr_d = act_fpr_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;

    case (sel_s)
      SEL_FCR: rdata_s = {30'd0, fcr_q};
      SEL_FDR: rdata_s = {16'd0, stg_fdr_q};
      SEL_FPR: rdata_s = {24'd0, stg_fpr_q};
      SEL_FSR: rdata_s = {29'd0, pending_q, idx_q};
      default: rdata_s = 32'd0;
    endcase

    if (rd_s) begin
      prdata_d = rdata_s;
    end else begin
      prdata_d = prdata_q;
    end

    if (wr_s) begin
      case (sel_s)
        SEL_FCR: fcr_d     = PWDATA[1:0];
        SEL_FDR: stg_fdr_d = PWDATA[15:0];
        SEL_FPR: stg_fpr_d = PWDATA[7:0];
        default: fcr_d     = fcr_q;
      endcase
    end else begin
      fcr_d = fcr_q;
    end

    // Active copies take the pre-edge staging value, so a write landing on a
    // boundary is shown one frame later and keeps pending set.
    if (!sync_mode_s || boundary_s) begin
      act_fdr_d = stg_fdr_q;
      act_fpr_d = stg_fpr_q;
    end else begin
      act_fdr_d = act_fdr_q;
      act_fpr_d = act_fpr_q;
    end

    if (!sync_mode_s) begin
      pending_d = 1'b0;
    end else if (wr_disp_s) begin
      pending_d = 1'b1;
    end else if (boundary_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    // Counters run only while enabled before and after this edge; clearing or
    // setting EN zeroes them on the same edge the FCR write commits.
    if (en_s && fcr_d[FCR_EN_BIT]) begin
      if (cnt_q == TERM) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
      end
    end else begin
      cnt_d = '0;
      idx_d = 2'd0;
    end

    // Predict the tick so the registered pulse lines up with the tick cycle.
    frame_done_d = fcr_d[FCR_EN_BIT] & (cnt_d == TERM) & (idx_d == 2'd3);
  end

  // State registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pready_q     <= 1'b0;
      prdata_q     <= 32'd0;
      fcr_q        <= 2'd0;
      stg_fdr_q    <= 16'd0;
      stg_fpr_q    <= 8'd0;
      act_fdr_q    <= 16'd0;
      act_fpr_q    <= 8'd0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      pready_q     <= pready_d;
      prdata_q     <= prdata_d;
      fcr_q        <= fcr_d;
      stg_fdr_q    <= stg_fdr_d;
      stg_fpr_q    <= stg_fpr_d;
      act_fdr_q    <= act_fdr_d;
      act_fpr_q    <= act_fpr_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  fnd_seg_decode u_seg (
    .nibble_i (act_fdr_q[{idx_q, 2'b00} +: 4]),
    .dot_i    (act_fpr_q[idx_q]),
    .blank_i  (act_fpr_q[{1'b1, idx_q}]),
    .font_o   (seg_font_s)
  );

  // Display drive: blank while disabled.
  always_comb begin
    fndComm = 4'hF;
    fndFont = 8'hFF;
    if (en_s) begin
      fndComm = comm_decode(idx_q);
      fndFont = seg_font_s;
    end else begin
      fndComm = 4'hF;
      fndFont = 8'hFF;
    end
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PENABLE, PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [3:0]  fndComm;
  logic [7:0]  fndFont;
  logic        frame_done;

  fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA),
    .PREADY(PREADY), .fndComm(fndComm), .fndFont(fndFont), .frame_done(frame_done)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [3:0] comm;
    logic [7:0] font;
    logic       fd;
  } disp_t;

  disp_t       disp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Expected-state tracker (fonts as {digit3,digit2,digit1,digit0}, hand-computed).
  logic        ben = 1'b0, bsync = 1'b0, bpend = 1'b0;
  int          ecnt = 0;
  logic [1:0]  eidx = 2'd0;
  logic [31:0] exp_act = 32'd0, exp_stg = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Push the expected display for the current cycle.
  task automatic pd();
    disp_t e;
    if (!ben) begin
      e.comm = 4'hF; e.font = 8'hFF; e.fd = 1'b0;
    end else begin
      case (eidx)
        2'd0:    e.comm = 4'b1110;
        2'd1:    e.comm = 4'b1101;
        2'd2:    e.comm = 4'b1011;
        default: e.comm = 4'b0111;
      endcase
      e.font = exp_act[int'(eidx)*8 +: 8];
      e.fd   = (ecnt == 3) && (eidx == 2'd3);
    end
    disp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge PCLK); #1;
    cyc++;
    if (ben && bsync) begin
      if (ecnt == 3 && eidx == 2'd3 && bpend) begin
        exp_act = exp_stg;
        bpend   = 1'b0;
      end
    end else begin
      exp_act = exp_stg;
      bpend   = 1'b0;
    end
    if (ben) begin
      if (ecnt == 3) begin
        ecnt = 0;
        eidx = eidx + 2'd1;
      end else begin
        ecnt = ecnt + 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      pd(); step();
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, input logic [31:0] fonts);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
    pd(); step();
    PENABLE = 1'b1;
    pd(); step();
    case (addr[3:2])
      2'd0: begin
        ben = data[0]; bsync = data[1];
        if (!data[0]) begin ecnt = 0; eidx = 2'd0; end
      end
      2'd1, 2'd2: begin
        if (ben && bsync) bpend = 1'b1;
        exp_stg = fonts;
      end
      default: ;
    endcase
    pd(); step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, input logic [31:0] exp, input bit is_fsr);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
    pd(); step();
    PENABLE = 1'b1;
    if (is_fsr) rd_q.push_back({29'd0, bpend, eidx});
    else        rd_q.push_back(exp);
    pd(); step();
    pd(); step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents display or read data.
  initial begin
    disp_t e;
    logic [31:0] r;
    logic prev_rdy = 1'b0;
    forever begin
      @(negedge PCLK);
      if (disp_q.size() > 0) begin
        e = disp_q.pop_front();
        checks++;
        if (fndComm !== e.comm || fndFont !== e.font || frame_done !== e.fd) begin
          errors++;
          $display("FAIL disp: got comm=%b font=%h fd=%b expected comm=%b font=%h fd=%b (cycle %0d)",
                   fndComm, fndFont, frame_done, e.comm, e.font, e.fd, cyc);
        end
      end
      if (PREADY === 1'b1 && !PWRITE) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got PRDATA=%h expected no read (cycle %0d)", PRDATA, cyc);
        end else begin
          r = rd_q.pop_front();
          if (PRDATA !== r) begin
            errors++;
            $display("FAIL rdata: got %h expected %h (cycle %0d)", PRDATA, r, cyc);
          end
        end
      end
      if (prev_rdy) begin
        checks++;
        if (PREADY !== 1'b0) begin
          errors++;
          $display("FAIL pready_width: got PREADY=%b expected 0 after one cycle (cycle %0d)", PREADY, cyc);
        end
      end
      prev_rdy = (PREADY === 1'b1);
    end
  end

  initial begin
    PRESET = 1'b1; PADDR = 4'h0; PWDATA = 32'd0; PWRITE = 1'b0; PENABLE = 1'b0; PSEL = 1'b0;
    @(negedge PCLK);
    chk("rst_comm",  {28'd0, fndComm}, 32'h0000000F);
    chk("rst_font",  {24'd0, fndFont}, 32'h000000FF);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    apb_read(4'h0, 32'd0, 1'b0);
    apb_read(4'h4, 32'd0, 1'b0);
    apb_read(4'h8, 32'd0, 1'b0);
    apb_read(4'hC, 32'd0, 1'b1);

    // Digits 1234, then enable: 99,B0,A4,F9 with frame_done every 16 cycles.
    apb_write(4'h4, 32'h0000_1234, 32'hF9A4B099);
    apb_read(4'h4, 32'h0000_1234, 1'b0);
    apb_write(4'h0, 32'd1, 32'd0);
    run(32);

    // SYNC mode: ABCD held back until the frame boundary.
    apb_write(4'h0, 32'd3, 32'd0);
    run(5);
    apb_write(4'h4, 32'h0000_ABCD, 32'h8883C6A1);
    apb_read(4'hC, 32'd0, 1'b1);
    run(40);
    apb_read(4'hC, 32'd0, 1'b1);
    apb_read(4'h4, 32'h0000_ABCD, 1'b0);

    // Write mid-frame, then a second write committing on the boundary edge.
    apb_write(4'h4, 32'h0000_5678, 32'h9282F880);
    for (int k = 0; k < 32 && !(ecnt == 2 && eidx == 2'd3); k++) begin
      pd(); step();
    end
    apb_write(4'h4, 32'h0000_1234, 32'hF9A4B099);
    apb_read(4'hC, 32'd0, 1'b1);
    run(34);
    apb_read(4'hC, 32'd0, 1'b1);

    // Back to immediate mode; dot on digit0, blank digit1.
    apb_write(4'h0, 32'd1, 32'd0);
    apb_write(4'h8, 32'h0000_0021, 32'hF9A4FF19);
    run(16);
    apb_read(4'h8, 32'h0000_0021, 1'b0);

    // FSR is read-only.
    apb_write(4'hC, 32'hFFFF_FFFF, 32'd0);
    apb_read(4'hC, 32'd0, 1'b1);

    // Disable on digit 2, then re-enable from digit 0.
    for (int k = 0; k < 32 && !(ecnt == 0 && eidx == 2'd2); k++) begin
      pd(); step();
    end
    apb_write(4'h0, 32'd0, 32'd0);
    run(3);
    apb_write(4'h0, 32'd1, 32'd0);
    run(8);

    // Reset during the access phase of a write.
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 4'h4; PWDATA = 32'h0000_FFFF; PENABLE = 1'b0;
    pd(); step();
    PENABLE = 1'b1;
    #1 PRESET = 1'b1;
    ben = 1'b0; bsync = 1'b0; bpend = 1'b0; ecnt = 0; eidx = 2'd0;
    exp_act = 32'd0; exp_stg = 32'd0;
    pd(); step();
    chk("rst_mid_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_mid_prdata", PRDATA, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    pd(); step();
    PRESET = 1'b0;
    pd(); step();
    apb_read(4'h0, 32'd0, 1'b0);
    apb_read(4'h4, 32'd0, 1'b0);
    apb_read(4'h8, 32'd0, 1'b0);
    apb_read(4'hC, 32'd0, 1'b1);

    pd(); step();
    chk("drain_disp", disp_q.size(), 32'd0);
    chk("drain_rd", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
